// File: rtl/prio_codec_pipe.sv
// rtl/prio_codec_pipe.sv - two-stage pipelined leading-zero/leading-one counter
//
// Purpose: counts the bits at the top of the word that equal the skip value.
// The skip value is 0 for Mode_i=0 and 1 for Mode_i=1. This is used for
// mantissa normalisation. A valid/ready handshake gives full backpressure.
//
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-low reset
//   Data_Dec_i [W]   word to scan, bit W-1 scanned first
//   Mode_i           0 = leading zeros, 1 = leading ones
//   Valid_i/Ready_o  input handshake
//   Data_Bin_o [CW]  leading-bit count, 0..W
//   All_o            every data bit equalled the skip value
//   Valid_o/Ready_i  output handshake
module prio_codec_pipe #(
  parameter int W  = 55,
  parameter int G  = 8,
  parameter int CW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  Data_Dec_i,
  input  logic          Mode_i,
  input  logic          Valid_i,
  output logic          Ready_o,
  output logic [CW-1:0] Data_Bin_o,
  output logic          All_o,
  output logic          Valid_o,
  input  logic          Ready_i
);

  localparam int NG   = (W + G - 1) / G;
  localparam int PW   = NG * G;
  localparam int PADN = PW - W;
  localparam int GCW  = $clog2(G + 1);

  logic            w_adv1, w_adv2;
  logic [PW-1:0]   w_padded;
  logic [GCW-1:0]  w_cnt [NG];
  logic [NG-1:0]   w_full;
  logic [CW-1:0]   w_sum;

  logic            r_v1, r_v2;
  logic [GCW-1:0]  r_cnt1 [NG];
  logic [NG-1:0]   r_full1;
  logic [CW-1:0]   r_cnt2;
  logic            r_all2;

  assign w_adv2  = ~r_v2 | Ready_i;
  assign w_adv1  = ~r_v1 | w_adv2;
  assign Ready_o = w_adv1;

  // The LSB padding bits hold the terminating value. A word made only of skip
  // bits therefore stops exactly at W and never runs into the padding.
  always_comb begin
    for (int i = 0; i < PW; i++) begin
      if (i < PADN) w_padded[i] = ~Mode_i;
      else          w_padded[i] = Data_Dec_i[i-PADN];
    end
  end

  // Per-group leading run. Group 0 is the MSB group.
  always_comb begin
    for (int k = 0; k < NG; k++) begin
      int   c;
      logic run;
      c   = 0;
      run = 1'b1;
      for (int j = 0; j < G; j++) begin
        if (run && (w_padded[PW-1-k*G-j] == Mode_i)) c = c + 1;
        else                                         run = 1'b0;
      end
      w_cnt[k]  = GCW'(c);
      w_full[k] = (c == G);
    end
  end

  // After stage 1 the count no longer depends on the mode. Only the group
  // counts and full flags are carried forward.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v1    <= 1'b0;
      r_full1 <= '0;
      for (int k = 0; k < NG; k++) r_cnt1[k] <= '0;
    end else if (w_adv1) begin
      r_v1    <= Valid_i;
      r_full1 <= w_full;
      r_cnt1  <= w_cnt;
    end
  end

  // Full groups contribute G each. The first non-full group adds its partial
  // count and ends the run.
  always_comb begin
    int   s;
    logic run;
    s   = 0;
    run = 1'b1;
    for (int k = 0; k < NG; k++) begin
      if (run) begin
        s = s + (r_full1[k] ? G : int'(r_cnt1[k]));
        if (!r_full1[k]) run = 1'b0;
      end
    end
    w_sum = CW'(s);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v2   <= 1'b0;
      r_cnt2 <= '0;
      r_all2 <= 1'b0;
    end else if (w_adv2) begin
      r_v2   <= r_v1;
      r_cnt2 <= w_sum;
      r_all2 <= (w_sum == CW'(W));
    end
  end

  // Invalid stage contents are don't-care internally. They are masked here
  // so that idle outputs always read as zero.
  assign Valid_o    = r_v2;
  assign Data_Bin_o = r_v2 ? r_cnt2 : '0;
  assign All_o      = r_v2 & r_all2;

endmodule

// File: tb/tb_prio_codec_pipe.sv
// tb/tb_prio_codec_pipe.sv - scoreboard bench for prio_codec_pipe
module tb_prio_codec_pipe;

  logic        clk = 1'b0;
  logic        rst;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  logic [54:0] d_a;
  logic        mode_a, vin_a, rdy_o_a, all_a, vo_a, rdy_i_a;
  logic [5:0]  cnt_a;

  logic [7:0]  d_b;
  logic        mode_b, vin_b, rdy_o_b, all_b, vo_b;
  logic [3:0]  cnt_b;

  typedef struct {
    int   cnt;
    logic all;
    int   cyc;
    logic lat;
  } exp_t;

  exp_t        sb_a[$];
  exp_t        sb_b[$];
  logic        lat_en = 1'b1;
  logic        stall_prev = 1'b0;
  logic [5:0]  hold_cnt;
  logic        hold_all;

  prio_codec_pipe #(.W(55), .G(8)) u_dut_a (
    .clk(clk), .rst(rst), .Data_Dec_i(d_a), .Mode_i(mode_a), .Valid_i(vin_a),
    .Ready_o(rdy_o_a), .Data_Bin_o(cnt_a), .All_o(all_a), .Valid_o(vo_a),
    .Ready_i(rdy_i_a)
  );

  prio_codec_pipe #(.W(8), .G(3)) u_dut_b (
    .clk(clk), .rst(rst), .Data_Dec_i(d_b), .Mode_i(mode_b), .Valid_i(vin_b),
    .Ready_o(rdy_o_b), .Data_Bin_o(cnt_b), .All_o(all_b), .Valid_o(vo_b),
    .Ready_i(1'b1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int lead(input logic [63:0] d, input logic m, input int w);
    int n;
    n = 0;
    for (int i = w - 1; i >= 0; i--) begin
      if (d[i] != m) break;
      n++;
    end
    return n;
  endfunction

  function automatic logic [54:0] mk(input int n, input logic m);
    logic [54:0] d;
    d = 55'({$urandom, $urandom});
    for (int i = 0; i < n; i++) d[54-i] = m;
    if (n < 55) d[54-n] = ~m;
    return d;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (vin_a && rdy_o_a) begin
        exp_t e;
        e.cnt = lead(64'(d_a), mode_a, 55);
        e.all = (e.cnt == 55);
        e.cyc = cyc;
        e.lat = lat_en;
        sb_a.push_back(e);
      end
      if (vo_a) begin
        if (stall_prev) begin
          check("hold_cnt", 32'(cnt_a), 32'(hold_cnt));
          check("hold_all", 32'(all_a), 32'(hold_all));
        end
        if (!rdy_i_a) begin
          stall_prev = 1'b1;
          hold_cnt   = cnt_a;
          hold_all   = all_a;
        end else begin
          stall_prev = 1'b0;
          if (sb_a.size() == 0) check("unexpected_out_a", 32'd1, 32'd0);
          else begin
            exp_t e;
            e = sb_a.pop_front();
            check("cnt_a", 32'(cnt_a), 32'(e.cnt));
            check("all_a", 32'(all_a), 32'(e.all));
            if (e.lat) check("latency_a", 32'(cyc - e.cyc), 32'd2);
          end
        end
      end else begin
        if (stall_prev) check("hold_valid", 32'(vo_a), 32'd1);
        stall_prev = 1'b0;
        check("idle_zero_a", {26'd0, cnt_a, all_a}, 32'd0);
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (vin_b && rdy_o_b) begin
        exp_t e;
        e.cnt = lead(64'(d_b), mode_b, 8);
        e.all = (e.cnt == 8);
        e.cyc = cyc;
        e.lat = 1'b1;
        sb_b.push_back(e);
      end
      if (vo_b) begin
        if (sb_b.size() == 0) check("unexpected_out_b", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = sb_b.pop_front();
          check("cnt_b", 32'(cnt_b), 32'(e.cnt));
          check("all_b", 32'(all_b), 32'(e.all));
          check("latency_b", 32'(cyc - e.cyc), 32'd2);
        end
      end
    end
  end

  task automatic send_a(input logic [54:0] d, input logic m);
    d_a = d; mode_a = m; vin_a = 1'b1;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (rdy_o_a) break;
      if (t > 100) begin check("send_timeout_a", 32'd0, 32'd1); break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic send_b(input logic [7:0] d, input logic m);
    d_b = d; mode_b = m; vin_b = 1'b1;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (rdy_o_b) break;
      if (t > 100) begin check("send_timeout_b", 32'd0, 32'd1); break; end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0;
    d_a = '0; mode_a = 1'b0; vin_a = 1'b0; rdy_i_a = 1'b1;
    d_b = '0; mode_b = 1'b0; vin_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(vo_a), 32'd0);
    check("rst_cnt", 32'(cnt_a), 32'd0);
    check("rst_all", 32'(all_a), 32'd0);
    check("rst_ready", 32'(rdy_o_a), 32'd1);
    check("rst_valid_b", 32'(vo_b), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    send_a(55'd1 << 54, 1'b0);
    send_a(55'd1, 1'b0);
    send_a(55'd0, 1'b0);
    send_a({55{1'b1}}, 1'b1);
    send_a(mk(25, 1'b1), 1'b1);
    for (int n = 0; n < 55; n++) send_a(mk(n, 1'b1), 1'b1);
    for (int n = 0; n < 55; n++) send_a(mk(n, 1'b0), 1'b0);
    for (int i = 0; i < 20; i++) begin
      logic m;
      m = 1'($urandom);
      send_a(mk($urandom_range(0, 55), m), m);
    end
    vin_a = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    lat_en = 1'b0;
    fork
      begin
        send_a(mk(3, 1'b0), 1'b0);
        send_a(mk(17, 1'b1), 1'b1);
        send_a(mk(55, 1'b0), 1'b0);
        vin_a = 1'b0;
      end
      begin
        rdy_i_a = 1'b0;
        repeat (3) @(negedge clk);
        check("stall_ready_low", 32'(rdy_o_a), 32'd0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rdy_i_a = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    lat_en = 1'b1;

    send_a(mk(9, 1'b1), 1'b1);
    send_a(mk(40, 1'b0), 1'b0);
    vin_a = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("midrst_valid", 32'(vo_a), 32'd0);
    check("midrst_cnt", 32'(cnt_a), 32'd0);
    check("midrst_ready", 32'(rdy_o_a), 32'd1);
    sb_a.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    send_a(mk(31, 1'b1), 1'b1);
    vin_a = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    send_b(8'h00, 1'b0);
    send_b(8'h01, 1'b0);
    send_b(8'hFF, 1'b1);
    send_b(8'h80, 1'b0);
    send_b(8'hF0, 1'b1);
    send_b(8'h1F, 1'b0);
    vin_b = 1'b0;

    for (int t = 0; t < 50; t++) begin
      if (sb_a.size() == 0 && sb_b.size() == 0) break;
      @(posedge clk);
    end
    check("drain_a", 32'(sb_a.size()), 32'd0);
    check("drain_b", 32'(sb_b.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
